vip_frame_cfg_ctrl: RTL and testbench
=====================================

# vip_frame_cfg_ctrl

Frame-synchronous configuration controller for the video processing pipeline. It holds the pipeline stage enables (histogram equalisation, Sobel, YUV→RGB, downscale) and the downscale factor in software-writable staging registers behind an Avalon-MM slave. It transfers them to the pipeline control inputs only at a frame boundary, so a frame is never processed with mixed settings. It sits beside the pipeline on the pixel clock and also provides a frame counter and a commit-done interrupt.

## Interface
- FRAME_CNT_W, 16, width of the free-running frame counter (1..32)
- pclk  in  1  pixel clock; all logic is clocked on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- avs_address  in  3  word address of the register
- avs_write  in  1  write strobe; single cycle, no waitrequest
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data; registered, 1-cycle latency
- in_vsync  in  1  pipeline input vsync; synchronous to pclk; high during vertical sync
- hist_equ_en  out  1  active histogram-equalisation enable
- sobel_en  out  1  active Sobel enable
- yuv2rgb_en  out  1  active YUV→RGB enable
- dscale_en  out  1  active downscale enable
- dscale_scale  out  4  active downscale factor code
- cfg_pending  out  1  a commit is waiting for a frame boundary
- frame_cnt  out  FRAME_CNT_W  count of frame boundaries since reset
- irq  out  1  level interrupt; commit applied and irq enabled

## Operation
- Register map (word address):
  - 0 CTRL, RW staging: [0] hist, [1] sobel, [2] yuv2rgb, [3] dscale, [7:4] scale. Other bits read 0.
  - 1 COMMIT, WO: writing bit0=1 sets pending. Writing bit1=1 applies staging immediately and clears pending.
  - 2 STATUS: [0] pending (RO), [1] irq flag (write 1 to clear).
  - 3 FRAME_CNT, RO, zero-extended.
  - 4 IRQ_EN: [0].
  - 5–7 read 0; writes to them are ignored.
- Frame boundary: rising edge of in_vsync, `in_vsync & ~vsync_d`, where vsync_d is in_vsync registered.
- Control FSM:
  - States are IDLE and PENDING. cfg_pending = (state == PENDING).
  - IDLE → PENDING on a COMMIT bit0 write.
  - PENDING → IDLE on a frame boundary. On that transition the active registers load from staging, irq_flag is set, and frame_cnt increments as on any boundary.
  - Either state → IDLE on a COMMIT bit1 write. Active registers load immediately and irq_flag is set.
- frame_cnt increments on every frame boundary in either state and wraps from all-ones to 0.
- irq = irq_flag & irq_en.

## Timing
- Reset values:
  - Active outputs and CTRL staging: hist 0, sobel 0, yuv2rgb 1, dscale 1, scale 4'd1.
  - State IDLE, cfg_pending 0, frame_cnt 0, irq_flag 0, irq_en 0, irq 0, avs_readdata 0, vsync_d 0.
- Latency from in_vsync rising (sampled high at edge k, low at edge k-1): active outputs, frame_cnt and irq update at edge k+1.
- A CTRL or COMMIT write sampled at edge k takes effect at edge k+1.
- avs_readdata is valid on the cycle after avs_read. It holds its value when avs_read is low.
- Boundary cases:
  - Frame boundary and COMMIT bit0 write in the same cycle while PENDING: the active registers load the pre-write staging, and the state stays PENDING.
  - Frame boundary and COMMIT bit0 write in the same cycle while IDLE: the state goes to PENDING, nothing is applied, and frame_cnt still increments.
  - Frame boundary and CTRL write in the same cycle while PENDING: the active registers get the old staging value, and staging updates.
  - COMMIT with bit0 and bit1 both set: bit1 wins. The configuration applies immediately and the state goes to IDLE.
  - irq_flag set and a write-1-clear in the same cycle: set wins.
  - in_vsync held high: only one boundary is counted. in_vsync high out of reset counts as a boundary at the first edge.
  - Asynchronous reset mid-PENDING: all state returns to the reset values and the pending commit is discarded.

## Test plan
- Reset, then read addresses 0–4 → 0x00000001C, 0, 0, 0, 0. Outputs: yuv2rgb 1, dscale 1, scale 1, all other outputs 0.
- Write CTRL = 0x23, then COMMIT = 1, then pulse in_vsync 1→0 three cycles later → cfg_pending is 1 until the edge after vsync rises. Then hist 1, sobel 1, yuv2rgb 0, dscale 0, scale 2, frame_cnt 1, STATUS = 0x2.
- Set IRQ_EN = 1 and COMMIT = 2 with no vsync → outputs update 1 cycle after the write and irq goes high. Write STATUS = 0x2 → irq low the next cycle.
- Assert COMMIT bit0 write and the in_vsync rise in the same cycle from IDLE → no apply, state PENDING. The next vsync applies the configuration.
- Apply 70000 vsync pulses with FRAME_CNT_W = 16 → frame_cnt = 4464 after wrap. Holding in_vsync high for 100 cycles adds exactly 1.
- Assert rst_n low asynchronously while PENDING → cfg_pending drops immediately and outputs return to the reset values. A later vsync applies nothing.

Source files
------------

// File: rtl/vip_frame_cfg_ctrl_if.sv
// Avalon-MM register bus between the host (master) and the frame config controller (slave).
interface vip_frame_cfg_ctrl_if;
   logic [2:0]  avs_address;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        avs_read;
   logic [31:0] avs_readdata;

   modport master (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata
   );
endinterface

// File: rtl/vip_frame_cfg_ctrl.sv
// Staging/active pipeline config registers swapped at vsync rise, plus frame counter and commit irq.
// Writes and boundaries act at the next pclk edge, readdata 1-cycle latency; no waitrequest, never stalls.
module vip_frame_cfg_ctrl #(
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   pclk,
   input  logic                   rst_n,
   vip_frame_cfg_ctrl_if.slave    bus,
   input  logic                   in_vsync,
   output logic                   hist_equ_en,
   output logic                   sobel_en,
   output logic                   yuv2rgb_en,
   output logic                   dscale_en,
   output logic [3:0]             dscale_scale,
   output logic                   cfg_pending,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   irq
);
   typedef enum logic {IDLE, PENDING} state_t;

   // Field order matches the CTRL register bit layout.
   typedef struct packed {
      logic [3:0] scale;
      logic       dscale;
      logic       yuv2rgb;
      logic       sobel;
      logic       hist;
   } cfg_t;

   localparam cfg_t CFG_RST = '{scale: 4'd1, dscale: 1'b1, yuv2rgb: 1'b1, sobel: 1'b0, hist: 1'b0};

   state_t                 state_q, state_d;
   cfg_t                   staging_q, active_q;
   logic                   vsync_d, irq_flag, irq_en, apply;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;
   logic [31:0]            rd_mux, readdata_q;
   logic                   frame_edge, wr_ctrl, wr_commit, wr_status, wr_irq_en;
   logic                   commit_req, commit_now;
   logic                   unused_wdata;

   assign frame_edge   = in_vsync & ~vsync_d;
   assign wr_ctrl      = bus.avs_write & (bus.avs_address == 3'd0);
   assign wr_commit    = bus.avs_write & (bus.avs_address == 3'd1);
   assign wr_status    = bus.avs_write & (bus.avs_address == 3'd2);
   assign wr_irq_en    = bus.avs_write & (bus.avs_address == 3'd4);
   assign commit_req   = wr_commit & bus.avs_writedata[0];
   assign commit_now   = wr_commit & bus.avs_writedata[1];
   assign unused_wdata = ^bus.avs_writedata[31:8];

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Immediate commit beats everything; a boundary applies the staging value seen before this edge.
   always_comb begin
      state_d = state_q;
      apply   = 1'b0;
      case (state_q)
         IDLE: begin
            if (commit_now) begin
               apply = 1'b1;
            end else if (commit_req) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (commit_now) begin
               apply   = 1'b1;
               state_d = IDLE;
            end else if (frame_edge) begin
               apply   = 1'b1;
               state_d = commit_req ? PENDING : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (bus.avs_address)
         3'd0:    rd_mux[7:0] = staging_q;
         3'd2:    rd_mux[1:0] = {irq_flag, state_q == PENDING};
         3'd3:    rd_mux[FRAME_CNT_W-1:0] = frame_cnt_q;
         3'd4:    rd_mux[0] = irq_en;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d     <= 1'b0;
         staging_q   <= CFG_RST;
         active_q    <= CFG_RST;
         frame_cnt_q <= '0;
         irq_flag    <= 1'b0;
         irq_en      <= 1'b0;
         readdata_q  <= '0;
      end else begin
         vsync_d <= in_vsync;
         if (wr_ctrl)
            staging_q <= cfg_t'(bus.avs_writedata[7:0]);
         if (apply)
            active_q <= staging_q;
         if (frame_edge)
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
         // A new commit outranks a simultaneous write-1-clear.
         if (apply)
            irq_flag <= 1'b1;
         else if (wr_status && bus.avs_writedata[1])
            irq_flag <= 1'b0;
         if (wr_irq_en)
            irq_en <= bus.avs_writedata[0];
         if (bus.avs_read)
            readdata_q <= rd_mux;
      end
   end

   assign bus.avs_readdata = readdata_q;
   assign hist_equ_en      = active_q.hist;
   assign sobel_en         = active_q.sobel;
   assign yuv2rgb_en       = active_q.yuv2rgb;
   assign dscale_en        = active_q.dscale;
   assign dscale_scale     = active_q.scale;
   assign cfg_pending      = (state_q == PENDING);
   assign frame_cnt        = frame_cnt_q;
   assign irq              = irq_flag & irq_en;
endmodule

// File: tb/tb_vip_frame_cfg_ctrl.sv
// Bench for vip_frame_cfg_ctrl: table of CTRL/commit vectors, hand sequences for boundary races,
// reset and counter wrap; register reads are checked through an expected-value queue.
module tb_vip_frame_cfg_ctrl;
   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic        rst_n, in_vsync, w_vsync;
   logic        hist_equ_en, sobel_en, yuv2rgb_en, dscale_en, cfg_pending, irq;
   logic [3:0]  dscale_scale;
   logic [15:0] frame_cnt;
   logic        w_hist, w_sobel, w_yuv, w_ds, w_pend, w_irq;
   logic [3:0]  w_scale;
   logic [7:0]  w_fcnt;

   vip_frame_cfg_ctrl_if bus();
   vip_frame_cfg_ctrl_if w_bus();

   vip_frame_cfg_ctrl #(.FRAME_CNT_W(16)) dut (
      .pclk(pclk), .rst_n(rst_n), .bus(bus), .in_vsync(in_vsync),
      .hist_equ_en(hist_equ_en), .sobel_en(sobel_en), .yuv2rgb_en(yuv2rgb_en),
      .dscale_en(dscale_en), .dscale_scale(dscale_scale), .cfg_pending(cfg_pending),
      .frame_cnt(frame_cnt), .irq(irq)
   );

   vip_frame_cfg_ctrl #(.FRAME_CNT_W(8)) dut_w (
      .pclk(pclk), .rst_n(rst_n), .bus(w_bus), .in_vsync(w_vsync),
      .hist_equ_en(w_hist), .sobel_en(w_sobel), .yuv2rgb_en(w_yuv),
      .dscale_en(w_ds), .dscale_scale(w_scale), .cfg_pending(w_pend),
      .frame_cnt(w_fcnt), .irq(w_irq)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } rd_exp_t;
   rd_exp_t sb_q[$];
   logic    rd_seen = 1'b0;

   typedef struct {
      logic [31:0] wdata;
      logic        via_vsync;
      logic [31:0] exp_ctrl;
      logic [7:0]  exp_act;
   } vec_t;
   vec_t vecs[6];

   logic [7:0]  cur_act;
   logic [15:0] exp_fcnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [7:0] exp);
      chk(name, {24'h0, dscale_scale, dscale_en, yuv2rgb_en, sobel_en, hist_equ_en}, {24'h0, exp});
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic wr(input logic [2:0] addr, input logic [31:0] data);
      bus.avs_address   = addr;
      bus.avs_writedata = data;
      bus.avs_write     = 1'b1;
      tick();
      bus.avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
      rd_exp_t e;
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
      bus.avs_address = addr;
      bus.avs_read    = 1'b1;
      tick();
      bus.avs_read    = 1'b0;
   endtask

   task automatic vsync_pulse();
      in_vsync = 1'b1;
      tick();
      in_vsync = 1'b0;
      tick();
   endtask

   always @(posedge pclk) rd_seen <= bus.avs_read;

   always @(negedge pclk) begin
      rd_exp_t e;
      if (rd_seen) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got read data 0x%0h expected no read", bus.avs_readdata);
         end else begin
            e = sb_q.pop_front();
            chk(e.name, bus.avs_readdata, e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0000_0023, 1'b1, 32'h23, 8'h23};
      vecs[1] = '{32'h0000_005A, 1'b0, 32'h5A, 8'h5A};
      vecs[2] = '{32'hFFFF_FFFF, 1'b1, 32'hFF, 8'hFF};
      vecs[3] = '{32'h0000_1234, 1'b0, 32'h34, 8'h34};
      vecs[4] = '{32'h0000_0000, 1'b1, 32'h00, 8'h00};
      vecs[5] = '{32'h0000_00F0, 1'b0, 32'hF0, 8'hF0};

      rst_n = 1'b0; in_vsync = 1'b0; w_vsync = 1'b0;
      bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
      w_bus.avs_address = '0; w_bus.avs_write = 1'b0; w_bus.avs_writedata = '0; w_bus.avs_read = 1'b0;
      repeat (3) tick();
      chk_out("act_in_reset", 8'h1C);
      rst_n = 1'b1;
      tick();

      // Reset state
      rd(3'd0, 32'h1C, "rst_ctrl");
      rd(3'd1, 32'h0, "rst_commit");
      rd(3'd2, 32'h0, "rst_status");
      rd(3'd3, 32'h0, "rst_fcnt_reg");
      rd(3'd4, 32'h0, "rst_irq_en");
      chk_out("rst_act", 8'h1C);
      chk("rst_pending", cfg_pending, 0);
      chk("rst_fcnt", frame_cnt, 0);
      chk("rst_irq", irq, 0);
      chk("rst_w_fcnt", w_fcnt, 0);
      chk("rst_w_rdata", w_bus.avs_readdata, 0);
      wr(3'd5, 32'hFFFF_FFFF);
      rd(3'd5, 32'h0, "addr5_rd");
      rd(3'd7, 32'h0, "addr7_rd");
      rd(3'd0, 32'h1C, "ctrl_after_addr5");

      cur_act  = 8'h1C;
      exp_fcnt = 16'd0;

      for (int i = 0; i < 6; i++) begin
         wr(3'd0, vecs[i].wdata);
         rd(3'd0, vecs[i].exp_ctrl, "vec_ctrl_rb");
         chk_out("vec_staging_no_apply", cur_act);
         if (vecs[i].via_vsync) begin
            wr(3'd1, 32'h1);
            chk("vec_pending_set", cfg_pending, 1);
            tick(); tick();
            chk("vec_pending_hold", cfg_pending, 1);
            chk_out("vec_act_hold", cur_act);
            in_vsync = 1'b1;
            tick();
            in_vsync = 1'b0;
            exp_fcnt++;
            chk("vec_pending_clr", cfg_pending, 0);
            chk_out("vec_act_vsync", vecs[i].exp_act);
            chk("vec_fcnt", frame_cnt, exp_fcnt);
            tick();
         end else begin
            wr(3'd1, 32'h2);
            chk("vec_now_pending", cfg_pending, 0);
            chk_out("vec_act_now", vecs[i].exp_act);
         end
         chk("vec_irq_masked", irq, 0);
         rd(3'd2, 32'h2, "vec_status_flag");
         wr(3'd2, 32'h2);
         rd(3'd2, 32'h0, "vec_status_clr");
         cur_act = vecs[i].exp_act;
      end

      // Immediate commit with irq enabled, then write-1-clear
      wr(3'd4, 32'h1);
      rd(3'd4, 32'h1, "irq_en_rb");
      chk("irq_low_before", irq, 0);
      wr(3'd0, 32'h11);
      wr(3'd1, 32'h2);
      chk("irq_now_high", irq, 1);
      chk_out("irq_now_act", 8'h11);
      wr(3'd2, 32'h2);
      chk("irq_cleared", irq, 0);

      // Boundary apply and write-1-clear in the same cycle: set wins
      wr(3'd0, 32'h22);
      wr(3'd1, 32'h1);
      bus.avs_address = 3'd2; bus.avs_writedata = 32'h2; bus.avs_write = 1'b1;
      in_vsync = 1'b1;
      tick();
      bus.avs_write = 1'b0; in_vsync = 1'b0;
      exp_fcnt++;
      chk("setwins_irq", irq, 1);
      chk_out("setwins_act", 8'h22);
      chk("setwins_pending", cfg_pending, 0);
      tick();
      wr(3'd2, 32'h2);
      chk("setwins_clr", irq, 0);

      // COMMIT bit0 and boundary together from IDLE: nothing applied, goes PENDING
      wr(3'd0, 32'h33);
      bus.avs_address = 3'd1; bus.avs_writedata = 32'h1; bus.avs_write = 1'b1;
      in_vsync = 1'b1;
      tick();
      bus.avs_write = 1'b0; in_vsync = 1'b0;
      exp_fcnt++;
      chk("idle_race_pending", cfg_pending, 1);
      chk_out("idle_race_no_apply", 8'h22);
      chk("idle_race_fcnt", frame_cnt, exp_fcnt);
      chk("idle_race_irq", irq, 0);
      rd(3'd2, 32'h1, "idle_race_status");
      vsync_pulse();
      exp_fcnt++;
      chk_out("idle_race_apply", 8'h33);
      chk("idle_race_done", cfg_pending, 0);
      wr(3'd2, 32'h2);

      // COMMIT bit0 and boundary together while PENDING: applies, stays PENDING
      wr(3'd0, 32'h44);
      wr(3'd1, 32'h1);
      bus.avs_address = 3'd1; bus.avs_writedata = 32'h1; bus.avs_write = 1'b1;
      in_vsync = 1'b1;
      tick();
      bus.avs_write = 1'b0; in_vsync = 1'b0;
      exp_fcnt++;
      chk_out("pend_race_apply", 8'h44);
      chk("pend_race_pending", cfg_pending, 1);
      tick();
      // CTRL write and boundary together while PENDING: old staging applied
      bus.avs_address = 3'd0; bus.avs_writedata = 32'h66; bus.avs_write = 1'b1;
      in_vsync = 1'b1;
      tick();
      bus.avs_write = 1'b0; in_vsync = 1'b0;
      exp_fcnt++;
      chk_out("ctrl_race_old", 8'h44);
      chk("ctrl_race_idle", cfg_pending, 0);
      tick();
      rd(3'd0, 32'h66, "ctrl_race_staging");
      vsync_pulse();
      exp_fcnt++;
      chk_out("ctrl_race_no_reapply", 8'h44);
      wr(3'd2, 32'h2);

      // COMMIT with both bits: immediate apply, IDLE
      wr(3'd0, 32'h77);
      wr(3'd1, 32'h1);
      wr(3'd1, 32'h3);
      chk("both_pend_idle", cfg_pending, 0);
      chk_out("both_pend_act", 8'h77);
      wr(3'd0, 32'h78);
      wr(3'd1, 32'h3);
      chk("both_idle_idle", cfg_pending, 0);
      chk_out("both_idle_act", 8'h78);
      vsync_pulse();
      exp_fcnt++;
      chk_out("both_vsync_no_change", 8'h78);
      chk("both_fcnt", frame_cnt, exp_fcnt);
      wr(3'd2, 32'h2);

      // vsync held high counts once
      in_vsync = 1'b1;
      repeat (100) tick();
      in_vsync = 1'b0;
      tick();
      exp_fcnt++;
      chk("held_fcnt", frame_cnt, exp_fcnt);
      rd(3'd3, {16'h0, exp_fcnt}, "held_fcnt_reg");

      // Asynchronous reset while PENDING
      wr(3'd0, 32'h99);
      wr(3'd1, 32'h1);
      chk("arst_pending_before", cfg_pending, 1);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pending_drop", cfg_pending, 0);
      chk_out("arst_act", 8'h1C);
      chk("arst_fcnt", frame_cnt, 0);
      chk("arst_irq", irq, 0);
      tick();
      rst_n = 1'b1;
      tick();
      vsync_pulse();
      exp_fcnt = 16'd1;
      chk_out("arst_vsync_act", 8'h1C);
      chk("arst_vsync_pending", cfg_pending, 0);
      chk("arst_vsync_fcnt", frame_cnt, exp_fcnt);
      rd(3'd0, 32'h1C, "arst_ctrl");
      rd(3'd2, 32'h0, "arst_status");
      rd(3'd4, 32'h0, "arst_irq_en");

      // Counter wrap on an 8-bit instance; the 16-bit one counts past 255
      for (int n = 0; n < 300; n++) begin
         in_vsync = 1'b1; w_vsync = 1'b1;
         tick();
         in_vsync = 1'b0; w_vsync = 1'b0;
         tick();
         exp_fcnt++;
         if (n == 254) chk("wrap_at_max", w_fcnt, 8'hFF);
         if (n == 255) chk("wrap_to_zero", w_fcnt, 8'h00);
      end
      chk("wrap_300", w_fcnt, 8'd44);
      chk("fcnt16_no_wrap", frame_cnt, exp_fcnt);

      tick(); tick();
      chk("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
